// File: rtl/prime_scan_pkg.sv
// Shared definitions for the prime scan engine: FSM state encoding and
// default operand geometry used by the interface, the engine and its bench.
package prime_scan_pkg;

    // Engine control states; the verdict/next-operand step is folded into
    // whichever state reaches the verdict, so it has no encoding of its own.
    typedef enum logic [1:0] {
        IDLE,
        CHECK,
        DIV,
        DONE
    } state_t;

    // Default operand width in bits (minimum 4).
    localparam int DEF_WIDTH   = 16;
    // Default number of operands scanned per request (minimum 1).
    localparam int DEF_NUM_OPS = 4;

endpackage : prime_scan_pkg

// File: rtl/prime_scan_if.sv
// Request/result bundle between the switch-entry sequencer (master) and the
// prime scan engine (slave). Operand k lives at ops[k*WIDTH +: WIDTH].
interface prime_scan_if
    import prime_scan_pkg::*;
#(
    parameter int WIDTH   = DEF_WIDTH,
    parameter int NUM_OPS = DEF_NUM_OPS
);

    localparam int CNT_W = $clog2(NUM_OPS + 1);

    logic [NUM_OPS*WIDTH-1:0] ops;
    logic                     start;
    logic                     busy;
    logic                     done;
    logic [NUM_OPS-1:0]       prime_mask;
    logic [CNT_W-1:0]         prime_count;
    logic [WIDTH-1:0]         max_prime;

    // Requester side: supplies operands and start, observes status/results.
    modport master (
        output ops, start,
        input  busy, done, prime_mask, prime_count, max_prime
    );

    // Engine side.
    modport slave (
        input  ops, start,
        output busy, done, prime_mask, prime_count, max_prime
    );

endinterface : prime_scan_if

// File: rtl/mod_divider.sv
// Restoring divider, one quotient bit per cycle. The first step is taken on
// the launch edge, so div_done is high exactly WIDTH cycles after the cycle
// in which go was sampled. Only the remainder is needed by the engine.
// go is ignored while a division is in progress.
module mod_divider #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             go,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] remainder,
    output logic             div_done
);

    localparam int CW = $clog2(WIDTH + 1);

    logic             running_q;
    logic [CW-1:0]    cnt_q;
    logic [WIDTH-1:0] rem_q;
    logic [WIDTH-1:0] shreg_q;
    logic [WIDTH-1:0] dvs_q;

    logic [WIDTH:0]   shifted;
    logic             no_borrow;
    logic [WIDTH-1:0] rem_next;

    // One restoring step, sourced from the inputs on launch and from the
    // working registers while running.
    // NOTE: every signal written here gets a default before any branch, so no
    // path leaves it unassigned and no latch is inferred.
    always_comb begin
        shifted   = '0;
        no_borrow = 1'b0;
        rem_next  = '0;
        if (running_q) begin
            shifted = {rem_q, shreg_q[WIDTH-1]};
            no_borrow = (shifted >= {1'b0, dvs_q});
            rem_next = no_borrow ? WIDTH'(shifted - {1'b0, dvs_q}) : shifted[WIDTH-1:0];
        end else begin
            shifted = {{WIDTH{1'b0}}, dividend[WIDTH-1]};
            no_borrow = (shifted >= {1'b0, divisor});
            rem_next = no_borrow ? WIDTH'(shifted - {1'b0, divisor}) : shifted[WIDTH-1:0];
        end
    end

    // Launch, iterate WIDTH-1 further steps, then pulse div_done.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            running_q <= 1'b0;
            cnt_q     <= '0;
            rem_q     <= '0;
            shreg_q   <= '0;
            dvs_q     <= '0;
            div_done  <= 1'b0;
        end else begin
            div_done <= 1'b0;
            if (running_q) begin
                rem_q   <= rem_next;
                shreg_q <= shreg_q << 1;
                cnt_q   <= cnt_q - CW'(1);
                if (cnt_q == CW'(1)) begin
                    running_q <= 1'b0;
                    div_done  <= 1'b1;
                end
            end else if (go) begin
                rem_q     <= rem_next;
                shreg_q   <= dividend << 1;
                dvs_q     <= divisor;
                cnt_q     <= CW'(WIDTH - 1);
                running_q <= 1'b1;
            end
        end
    end

    assign remainder = rem_q;

endmodule : mod_divider

// File: rtl/prime_scan_engine.sv
// Prime scan engine: latches NUM_OPS operands on start, tests each by trial
// division with divisors 2, 3, ... while d*d <= n, and reports a prime mask,
// prime count and (optionally) the largest prime operand.
// Build option: define PRIME_SCAN_MAX_EN to build the max_prime register and
// comparator; without it max_prime is tied to 0.
module prime_scan_engine
    import prime_scan_pkg::*;
#(
    parameter int WIDTH   = DEF_WIDTH,
    parameter int NUM_OPS = DEF_NUM_OPS
) (
    input  logic         clk,
    input  logic         rst,
    prime_scan_if.slave  bus
);

    localparam int CNT_W = $clog2(NUM_OPS + 1);
    localparam int KW    = (NUM_OPS > 1) ? $clog2(NUM_OPS) : 1;

    state_t             state_q, state_d;

    logic [WIDTH-1:0]   ops_q [NUM_OPS];
    logic [KW-1:0]      k_q;
    logic [WIDTH-1:0]   d_q;
    logic [NUM_OPS-1:0] mask_q;
    logic [CNT_W-1:0]   count_q;

    logic [WIDTH-1:0]   n;
    logic [2*WIDTH-1:0] d_wide;
    logic [2*WIDTH-1:0] d_sq;
    logic               last_op;

    logic               accept;
    logic               go;
    logic               verdict;
    logic               is_prime;
    logic               d_step;

    logic [WIDTH-1:0]   remainder;
    logic               div_done;

    assign n       = ops_q[k_q];
    assign d_wide  = {{WIDTH{1'b0}}, d_q};
    assign d_sq    = d_wide * d_wide;
    assign last_op = (k_q == KW'(NUM_OPS - 1));

    mod_divider #(.WIDTH(WIDTH)) u_div (
        .clk       (clk),
        .rst       (rst),
        .go        (go),
        .dividend  (n),
        .divisor   (d_q),
        .remainder (remainder),
        .div_done  (div_done)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // Next-state and per-cycle control: acceptance, divider launch, verdicts.
    always_comb begin
        state_d  = state_q;
        accept   = 1'b0;
        go       = 1'b0;
        verdict  = 1'b0;
        is_prime = 1'b0;
        d_step   = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    accept  = 1'b1;
                    state_d = CHECK;
                end
            end
            CHECK: begin
                if (n < WIDTH'(2)) begin
                    verdict = 1'b1;
                end else if (d_sq > {{WIDTH{1'b0}}, n}) begin
                    verdict  = 1'b1;
                    is_prime = 1'b1;
                end else begin
                    go      = 1'b1;
                    state_d = DIV;
                end
                if (verdict) state_d = last_op ? DONE : CHECK;
            end
            DIV: begin
                if (div_done) begin
                    if (remainder == '0) begin
                        verdict = 1'b1;
                        state_d = last_op ? DONE : CHECK;
                    end else begin
                        d_step  = 1'b1;
                        state_d = CHECK;
                    end
                end
            end
            DONE: begin
                if (!bus.start) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Operand capture at acceptance; held unchanged while the scan runs.
    // NOTE: the operand array is not reset: it is always written on
    // acceptance before any read, so a reset path would only add logic.
    always_ff @(posedge clk) begin
        if (accept) begin
            for (int i = 0; i < NUM_OPS; i++) begin
                ops_q[i] <= bus.ops[i*WIDTH +: WIDTH];
            end
        end
    end

    // Operand index, trial divisor, mask and count bookkeeping.
    always_ff @(posedge clk) begin
        if (rst) begin
            k_q     <= '0;
            d_q     <= WIDTH'(2);
            mask_q  <= '0;
            count_q <= '0;
        end else if (accept) begin
            k_q     <= '0;
            d_q     <= WIDTH'(2);
            mask_q  <= '0;
            count_q <= '0;
        end else begin
            if (d_step) d_q <= d_q + WIDTH'(1);
            if (verdict) begin
                d_q <= WIDTH'(2);
                if (is_prime) begin
                    mask_q[k_q] <= 1'b1;
                    count_q     <= count_q + CNT_W'(1);
                end
                if (!last_op) k_q <= k_q + KW'(1);
            end
        end
    end

`ifdef PRIME_SCAN_MAX_EN
    logic [WIDTH-1:0] max_q;

    // Running maximum over prime verdicts, cleared at acceptance.
    always_ff @(posedge clk) begin
        if (rst || accept) begin
            max_q <= '0;
        end else if (verdict && is_prime && (n > max_q)) begin
            max_q <= n;
        end
    end

    assign bus.max_prime = max_q;
`else
    assign bus.max_prime = '0;
`endif

    assign bus.busy        = (state_q == CHECK) || (state_q == DIV);
    assign bus.done        = (state_q == DONE);
    assign bus.prime_mask  = mask_q;
    assign bus.prime_count = count_q;

endmodule : prime_scan_engine

// File: tb/tb_prime_scan_engine.sv
// Directed bench for prime_scan_engine (WIDTH=16, NUM_OPS=4). Expected
// masks, counts, maxima and done offsets are hand-computed per scenario.
// Done offset is counted in cycles after acceptance (T+1 is offset 1).
module tb_prime_scan_engine;
    import prime_scan_pkg::*;

    localparam int W = 16;
    localparam int N = 4;

    logic clk = 1'b0;
    logic rst;
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    prime_scan_if #(.WIDTH(W), .NUM_OPS(N)) bus ();

    prime_scan_engine #(.WIDTH(W), .NUM_OPS(N)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
        end
    endtask

    // Expected max_prime depends on whether the comparator is built.
    function automatic logic [31:0] exp_max(input logic [31:0] v);
`ifdef PRIME_SCAN_MAX_EN
        return v;
`else
        return 32'd0 & v;
`endif
    endfunction

    // Present operands with start high; return at the first negedge after
    // acceptance (offset 1).
    task automatic launch(input logic [63:0] v);
        @(negedge clk);
        bus.ops   = v;
        bus.start = 1'b1;
        @(negedge clk);
    endtask

    // Advance until done, starting from offset start_off; report the offset
    // at which done was seen and how many of the waited cycles showed busy.
    task automatic wait_done(input string tag, input int start_off,
                             output int offset, output int busy_seen);
        offset    = start_off;
        busy_seen = 0;
        while (!bus.done && offset < 20000) begin
            if (bus.busy) busy_seen++;
            @(negedge clk);
            offset++;
        end
        check({tag, "_done_seen"}, 32'(bus.done), 32'd1);
        check({tag, "_busy_at_done"}, 32'(bus.busy), 32'd0);
    endtask

    task automatic check_results(input string tag, input logic [3:0] m,
                                 input logic [31:0] c, input logic [31:0] mx);
        check({tag, "_mask"},  32'(bus.prime_mask),  32'(m));
        check({tag, "_count"}, 32'(bus.prime_count), c);
        check({tag, "_max"},   32'(bus.max_prime),   mx);
    endtask

    task automatic check_zero_outputs(input string tag);
        check({tag, "_busy"}, 32'(bus.busy), 32'd0);
        check({tag, "_done"}, 32'(bus.done), 32'd0);
        check_results(tag, 4'b0000, 32'd0, 32'd0);
    endtask

    initial begin
        int off;
        int bsy;

        rst       = 1'b1;
        bus.start = 1'b0;
        bus.ops   = '0;
        repeat (3) @(negedge clk);
        check_zero_outputs("reset");
        rst = 1'b0;

        // Scenario 1: {3,2,1,0}, start held. busy T+1..T+4, done at T+5.
        launch({16'd3, 16'd2, 16'd1, 16'd0});
        check("s1_busy_t1", 32'(bus.busy), 32'd1);
        wait_done("s1", 1, off, bsy);
        check("s1_done_offset", 32'(off), 32'd5);
        check("s1_busy_cycles", 32'(bsy), 32'd4);
        check_results("s1", 4'b1100, 32'd2, exp_max(32'd3));
        repeat (3) @(negedge clk);
        check("s1_done_held", 32'(bus.done), 32'd1);
        check("s1_busy_held", 32'(bus.busy), 32'd0);
        bus.start = 1'b0;
        @(negedge clk);
        check("s1_done_drop", 32'(bus.done), 32'd0);
        check("s1_mask_stable", 32'(bus.prime_mask), 32'b1100);

        // Scenario 2: {4,65521,91,97}. Busy cycles: 97 -> 137, 91 -> 102,
        // 65521 -> 254*17+1 = 4319, 4 -> 17; total 4575, done at 4576.
        launch({16'd4, 16'd65521, 16'd91, 16'd97});
        wait_done("s2", 1, off, bsy);
        check("s2_done_offset", 32'(off), 32'd4576);
        check("s2_busy_cycles", 32'(bsy), 32'd4575);
        check_results("s2", 4'b0101, 32'd2, exp_max(32'd65521));
        bus.start = 1'b0;
        @(negedge clk);
        check("s2_done_drop", 32'(bus.done), 32'd0);
        check_results("s2_stable", 4'b0101, 32'd2, exp_max(32'd65521));

        // Scenario 3: rerun {9,25,49,1}; results clear at acceptance.
        // Busy: 1 -> 1, 49 -> 102, 25 -> 68, 9 -> 34; done at 206.
        launch({16'd9, 16'd25, 16'd49, 16'd1});
        check_results("s3_cleared", 4'b0000, 32'd0, 32'd0);
        wait_done("s3", 1, off, bsy);
        check("s3_done_offset", 32'(off), 32'd206);
        check_results("s3", 4'b0000, 32'd0, 32'd0);
        bus.start = 1'b0;
        @(negedge clk);

        // Scenario 4: {5,6,11,13}; mid-run the operands change and start
        // pulses. Busy: 13 -> 35, 11 -> 35, 6 -> 17, 5 -> 18; done at 106.
        launch({16'd5, 16'd6, 16'd11, 16'd13});
        repeat (10) @(negedge clk);
        bus.ops   = {16'd4, 16'd4, 16'd4, 16'd4};
        bus.start = 1'b0;
        @(negedge clk);
        bus.start = 1'b1;
        @(negedge clk);
        check("s4_busy_mid", 32'(bus.busy), 32'd1);
        bus.start = 1'b0;
        wait_done("s4", 13, off, bsy);
        check("s4_done_offset", 32'(off), 32'd106);
        check_results("s4", 4'b1011, 32'd3, exp_max(32'd13));
        @(negedge clk);

        // Scenario 5: reset mid-DIV while testing 65521 (op0=7 already
        // recorded), then {7,7,7,7}: 4*18 busy cycles, done at 73.
        launch({16'd7, 16'd7, 16'd65521, 16'd7});
        bus.start = 1'b0;
        repeat (60) @(negedge clk);
        check("s5_busy_pre_rst", 32'(bus.busy), 32'd1);
        check("s5_mask_pre_rst", 32'(bus.prime_mask), 32'b0001);
        rst = 1'b1;
        @(negedge clk);
        check_zero_outputs("s5_rst");
        rst = 1'b0;
        launch({16'd7, 16'd7, 16'd7, 16'd7});
        check("s5_busy_t1", 32'(bus.busy), 32'd1);
        wait_done("s5", 1, off, bsy);
        check("s5_done_offset", 32'(off), 32'd73);
        check_results("s5", 4'b1111, 32'd4, exp_max(32'd7));
        bus.start = 1'b0;
        @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_prime_scan_engine
